spi_slave_frontend: RTL

Serial-to-parallel SPI slave front end that sits between the external SPI master and the single-port SPI RAM. Deserializes 10-bit MOSI command words into `rx_data`/`rx_valid` for the RAM. On a read-data command, captures the RAM's `tx_data`/`tx_valid` response and serializes it MSB-first on MISO. Tracks whether a read address has been sent, so a leading `1` bit is routed to read-address or read-data handling.

---
 rtl/spi_slave_frontend.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/spi_slave_frontend.sv
// spi_slave_frontend: SPI slave front end between an external SPI master and
// the single-port SPI RAM. Deserializes 10-bit MOSI command words into
// rx_data/rx_valid. On a read-data command it captures the RAM's tx_data and
// serializes it MSB-first on MISO.
// Optional build macro: SPI_SLAVE_SVA_EN compiles in protocol assertions.
module spi_slave_frontend #(
    parameter int CMD_WIDTH  = 10,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  SS_n,
    input  logic                  MOSI,
    output logic                  MISO,
    output logic [CMD_WIDTH-1:0]  rx_data,
    output logic                  rx_valid,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid
);

    localparam int TXC_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [3:0]       LAST_BIT = 4'(CMD_WIDTH - 1);
    localparam logic [3:0]       FULL     = 4'(CMD_WIDTH);
    localparam logic [TXC_W-1:0] TX_LAST  = TXC_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CHK_CMD   = 3'd1,
        WRITE     = 3'd2,
        READ_ADD  = 3'd3,
        READ_DATA = 3'd4
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic                    r_rd_addr_done;
    logic [3:0]              r_cnt;        // command bits sampled so far
    logic [CMD_WIDTH-1:0]    r_rx_data;
    logic                    r_rx_valid;
    logic [DATA_WIDTH-1:0]   r_tx_sr;
    logic [TXC_W-1:0]        r_tx_cnt;     // index of the bit currently on MISO
    logic                    r_tx_busy;    // MISO is carrying read data
    logic                    r_tx_done;    // shift-out finished for this frame
    logic                    r_miso;

    assign MISO     = r_miso;
    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state: the first command bit picks the branch; SS_n high always wins
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (!SS_n) w_state_nxt = CHK_CMD;
            CHK_CMD: begin
                if (!MOSI)               w_state_nxt = WRITE;
                else if (r_rd_addr_done) w_state_nxt = READ_DATA;
                else                     w_state_nxt = READ_ADD;
            end
            default: w_state_nxt = r_state;
        endcase
        if (SS_n) w_state_nxt = IDLE;
    end

    // Datapath: command deserializer, rx strobe, read-address tracking, MISO shifter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_addr_done <= 1'b0;
            r_cnt          <= '0;
            r_rx_data      <= '0;
            r_rx_valid     <= 1'b0;
            r_tx_sr        <= '0;
            r_tx_cnt       <= '0;
            r_tx_busy      <= 1'b0;
            r_tx_done      <= 1'b0;
            r_miso         <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            if (SS_n) begin
                r_cnt     <= '0;
                r_miso    <= 1'b0;
                r_tx_busy <= 1'b0;
                r_tx_done <= 1'b0;
                // last bit already held a full cycle: the read counts as complete
                if (r_tx_busy && r_tx_cnt == TX_LAST) r_rd_addr_done <= 1'b0;
            end else begin
                case (r_state)
                    CHK_CMD: begin
                        r_rx_data <= {r_rx_data[CMD_WIDTH-2:0], MOSI};
                        r_cnt     <= 4'd1;
                    end
                    WRITE, READ_ADD, READ_DATA: begin
                        if (r_cnt != FULL) begin
                            r_rx_data <= {r_rx_data[CMD_WIDTH-2:0], MOSI};
                            r_cnt     <= r_cnt + 4'd1;
                            if (r_cnt == LAST_BIT) begin
                                r_rx_valid <= 1'b1;
                                if (r_state == READ_ADD) r_rd_addr_done <= 1'b1;
                            end
                        end else if (r_state == READ_DATA) begin
                            if (r_tx_busy) begin
                                if (r_tx_cnt == TX_LAST) begin
                                    r_miso         <= 1'b0;
                                    r_tx_busy      <= 1'b0;
                                    r_tx_done      <= 1'b1;
                                    r_rd_addr_done <= 1'b0;
                                end else begin
                                    r_tx_sr  <= {r_tx_sr[DATA_WIDTH-2:0], 1'b0};
                                    r_miso   <= r_tx_sr[DATA_WIDTH-2];
                                    r_tx_cnt <= r_tx_cnt + 1'b1;
                                end
                            end else if (!r_tx_done && tx_valid) begin
                                r_tx_sr   <= tx_data;
                                r_miso    <= tx_data[DATA_WIDTH-1];
                                r_tx_busy <= 1'b1;
                                r_tx_cnt  <= '0;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef SPI_SLAVE_SVA_EN
    a_rxv_single: assert property (@(posedge clk) disable iff (!rst_n)
        rx_valid |=> !rx_valid);
    a_rxv_full:   assert property (@(posedge clk) disable iff (!rst_n)
        rx_valid |-> (r_cnt == FULL));
    a_miso_quiet: assert property (@(posedge clk) disable iff (!rst_n)
        !r_tx_busy |-> !MISO);
    a_ss_idle:    assert property (@(posedge clk) disable iff (!rst_n)
        SS_n |=> (r_state == IDLE));
`else
`endif

endmodule
